// File: rtl/cache_arbiter_if.sv
// Purpose : bundles the cache-side (two clients) and memory-side handshake
//           signals of the cache arbiter.
// Modports: slave  - the arbiter's view (receives client/bus inputs, drives
//                    grants, response beats and the memory request)
//           master - the environment's view (caches and memory model)
// Cache side : cache_reqcyc/cache_req/cache_reqtag/cache_respack in,
//              cache_reqack/cache_respcyc/cache_resp/cache_resptag out.
// Memory side: bus_reqack/bus_respcyc/bus_resp/bus_resptag in,
//              bus_reqcyc/bus_req/bus_reqtag/bus_respack out.
interface cache_arbiter_if #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned TAGWIDTH = 13
);
    logic [1:0]            cache_reqcyc;
    logic [2*WORDSIZE-1:0] cache_req;
    logic [2*TAGWIDTH-1:0] cache_reqtag;
    logic [1:0]            cache_reqack;
    logic [1:0]            cache_respcyc;
    logic [WORDSIZE-1:0]   cache_resp;
    logic [TAGWIDTH-1:0]   cache_resptag;
    logic [1:0]            cache_respack;

    logic                  bus_reqcyc;
    logic [WORDSIZE-1:0]   bus_req;
    logic [TAGWIDTH-1:0]   bus_reqtag;
    logic                  bus_reqack;
    logic                  bus_respcyc;
    logic [WORDSIZE-1:0]   bus_resp;
    logic [TAGWIDTH-1:0]   bus_resptag;
    logic                  bus_respack;

    modport slave (
        input  cache_reqcyc, cache_req, cache_reqtag, cache_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        output cache_reqack, cache_respcyc, cache_resp, cache_resptag,
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );

    modport master (
        output cache_reqcyc, cache_req, cache_reqtag, cache_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag,
        input  cache_reqack, cache_respcyc, cache_resp, cache_resptag,
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack
    );
endinterface

// File: rtl/cache_arbiter.sv
// Purpose : round-robin arbiter sharing one memory bus between an I-cache
//           (client 0) and a D-cache (client 1). One line fill of BEATS
//           response beats is in flight at a time; beats are forwarded to
//           the granted client one cycle after they appear on the bus.
// Ports   : clk     - clock
//           reset   - asynchronous active-low reset
//           cif     - cache_arbiter_if.slave, all client and memory handshakes
//           err_tag - sticky tag-mismatch flag (only with ARB_TAGCHECK_EN)
// Options : define ARB_TAGCHECK_EN to drop (but still ack) beats whose tag
//           differs from the granted request tag and flag them on err_tag.
module cache_arbiter #(
    parameter int unsigned WORDSIZE = 64,
    parameter int unsigned TAGWIDTH = 13,
    parameter int unsigned BEATS    = 8
) (
    input  logic           clk,
    input  logic           reset,
`ifdef ARB_TAGCHECK_EN
    output logic           err_tag,
`endif
    cache_arbiter_if.slave cif
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [WORDSIZE-1:0]   req_q, req_d;
    logic [TAGWIDTH-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [1:0]            reqack_q, reqack_d;
    logic [1:0]            respcyc_q, respcyc_d;
    logic [WORDSIZE-1:0]   resp_q, resp_d;
    logic [TAGWIDTH-1:0]   resptag_q, resptag_d;
    logic                  bus_reqcyc_q, bus_reqcyc_d;
    logic                  bus_respack_q, bus_respack_d;

    logic                  any_req;
    logic                  pick;
    logic                  beat;
    logic                  tag_ok;
    logic                  fwd;
    logic                  last_beat;

    // Round robin: on contention the client not granted last time wins.
    assign any_req   = |cif.cache_reqcyc;
    assign pick      = (&cif.cache_reqcyc) ? ~last_q : cif.cache_reqcyc[1];

    // Bus beats only count while a fill is outstanding.
    assign beat      = cif.bus_respcyc && (state_q != IDLE);

`ifdef ARB_TAGCHECK_EN
    assign tag_ok    = (cif.bus_resptag == tag_q);
`else
    assign tag_ok    = 1'b1;
`endif

    assign fwd       = beat && tag_ok;
    assign last_beat = fwd && (cnt_q == CNT_W'(BEATS - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = REQ;
            end
            REQ: begin
                if (last_beat)           state_d = IDLE;
                else if (cif.bus_reqack) state_d = XFER;
            end
            XFER: begin
                if (last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_TAGCHECK_EN
    logic err_q, err_d;
`endif

    // Output / datapath next values; every output is registered.
    always_comb begin
        grant_d       = grant_q;
        last_d        = last_q;
        req_d         = req_q;
        tag_d         = tag_q;
        cnt_d         = cnt_q;
        reqack_d      = 2'b00;
        respcyc_d     = 2'b00;
        resp_d        = resp_q;
        resptag_d     = resptag_q;
        bus_reqcyc_d  = 1'b0;
        bus_respack_d = 1'b0;
`ifdef ARB_TAGCHECK_EN
        err_d         = err_q;
`endif

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d      = pick;
                    last_d       = pick;
                    req_d        = pick ? cif.cache_req[2*WORDSIZE-1:WORDSIZE]
                                        : cif.cache_req[WORDSIZE-1:0];
                    tag_d        = pick ? cif.cache_reqtag[2*TAGWIDTH-1:TAGWIDTH]
                                        : cif.cache_reqtag[TAGWIDTH-1:0];
                    reqack_d     = pick ? 2'b10 : 2'b01;
                    bus_reqcyc_d = 1'b1;
                end
            end
            REQ: begin
                // Hold the request until memory accepts it.
                bus_reqcyc_d = !cif.bus_reqack && !last_beat;
            end
            default: ;
        endcase

        // Every beat in a fill is acked; only matching beats go to the client.
        if (beat) begin
            bus_respack_d = 1'b1;
        end
        if (fwd) begin
            respcyc_d = grant_q ? 2'b10 : 2'b01;
            resp_d    = cif.bus_resp;
            resptag_d = cif.bus_resptag;
            cnt_d     = last_beat ? '0 : cnt_q + CNT_W'(1);
        end
`ifdef ARB_TAGCHECK_EN
        if (beat && !tag_ok) begin
            err_d = 1'b1;
        end
`endif
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q       <= 1'b0;
            last_q        <= 1'b1;
            req_q         <= '0;
            tag_q         <= '0;
            cnt_q         <= '0;
            reqack_q      <= 2'b00;
            respcyc_q     <= 2'b00;
            resp_q        <= '0;
            resptag_q     <= '0;
            bus_reqcyc_q  <= 1'b0;
            bus_respack_q <= 1'b0;
        end else begin
            grant_q       <= grant_d;
            last_q        <= last_d;
            req_q         <= req_d;
            tag_q         <= tag_d;
            cnt_q         <= cnt_d;
            reqack_q      <= reqack_d;
            respcyc_q     <= respcyc_d;
            resp_q        <= resp_d;
            resptag_q     <= resptag_d;
            bus_reqcyc_q  <= bus_reqcyc_d;
            bus_respack_q <= bus_respack_d;
        end
    end

`ifdef ARB_TAGCHECK_EN
    // Sticky tag-mismatch flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_tag = err_q;
`endif

    assign cif.cache_reqack  = reqack_q;
    assign cif.cache_respcyc = respcyc_q;
    assign cif.cache_resp    = resp_q;
    assign cif.cache_resptag = resptag_q;
    assign cif.bus_reqcyc    = bus_reqcyc_q;
    assign cif.bus_req       = req_q;
    assign cif.bus_reqtag    = tag_q;
    assign cif.bus_respack   = bus_respack_q;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

    localparam int unsigned W  = 64;
    localparam int unsigned T  = 13;
    localparam int unsigned NB = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter_if #(.WORDSIZE(W), .TAGWIDTH(T)) cif ();

`ifdef ARB_TAGCHECK_EN
    logic err_tag;
`endif

    cache_arbiter #(.WORDSIZE(W), .TAGWIDTH(T), .BEATS(NB)) dut (
        .clk     (clk),
        .reset   (reset),
`ifdef ARB_TAGCHECK_EN
        .err_tag (err_tag),
`endif
        .cif     (cif)
    );

    typedef struct {
        int           client;
        logic [W-1:0] data;
        logic [T-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   resp_acks = 0;
    int   reqack_pulses = 0;

    // One clock: inputs set before the call are sampled at posedge, outputs
    // observed at negedge; forwarded beats are popped against the scoreboard.
    task automatic tick();
        exp_t       e;
        logic [1:0] expc;
        @(posedge clk);
        @(negedge clk);
        if (reset) begin
            if (cif.bus_respack) resp_acks++;
            if (cif.cache_reqack != 2'b00) reqack_pulses++;
            if (cif.cache_respcyc != 2'b00) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_beat: unexpected beat respcyc=%b data=%h tag=%h",
                             cif.cache_respcyc, cif.cache_resp, cif.cache_resptag);
                end else begin
                    e    = exp_q.pop_front();
                    expc = (e.client == 1) ? 2'b10 : 2'b01;
                    if (cif.cache_respcyc !== expc || cif.cache_resp !== e.data ||
                        cif.cache_resptag !== e.tag) begin
                        $display("FAIL sb_beat: got respcyc=%b data=%h tag=%h, expected respcyc=%b data=%h tag=%h",
                                 cif.cache_respcyc, cif.cache_resp, cif.cache_resptag,
                                 expc, e.data, e.tag);
                    end else begin
                        n_pass++;
                    end
                end
            end
        end
    endtask

    task automatic clear_inputs();
        cif.cache_reqcyc  = 2'b00;
        cif.cache_req     = '0;
        cif.cache_reqtag  = '0;
        cif.cache_respack = 2'b00;
        cif.bus_reqack    = 1'b0;
        cif.bus_respcyc   = 1'b0;
        cif.bus_resp      = '0;
        cif.bus_resptag   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        resp_acks     = 0;
        reqack_pulses = 0;
    endtask

    task automatic set_client(input int c, input logic [W-1:0] addr, input logic [T-1:0] tag);
        if (c == 1) begin
            cif.cache_req[2*W-1:W]    = addr;
            cif.cache_reqtag[2*T-1:T] = tag;
        end else begin
            cif.cache_req[W-1:0]      = addr;
            cif.cache_reqtag[T-1:0]   = tag;
        end
        cif.cache_reqcyc[c] = 1'b1;
    endtask

    // Waits (bounded) for a reqack, checks it names the expected client, and
    // drops that client's request.
    task automatic wait_grant(input int exp_g, output int ticks);
        logic [1:0] expack;
        expack = (exp_g == 1) ? 2'b10 : 2'b01;
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (cif.cache_reqack == 2'b00 && ticks < 10);
        n_checks++;
        if (cif.cache_reqack !== expack)
            $display("FAIL grant: reqack=%b after %0d cycles, expected %b", cif.cache_reqack, ticks, expack);
        else
            n_pass++;
        cif.cache_reqcyc = cif.cache_reqcyc & ~cif.cache_reqack;
    endtask

    // Memory side accepts the forwarded request after 'delay' cycles.
    task automatic bus_accept(input logic [W-1:0] addr, input logic [T-1:0] tag, input int delay);
        n_checks++;
        if (cif.bus_reqcyc !== 1'b1 || cif.bus_req !== addr || cif.bus_reqtag !== tag)
            $display("FAIL bus_req: cyc=%b req=%h tag=%h, expected cyc=1 req=%h tag=%h",
                     cif.bus_reqcyc, cif.bus_req, cif.bus_reqtag, addr, tag);
        else
            n_pass++;
        repeat (delay) tick();
        n_checks++;
        if (cif.bus_reqcyc !== 1'b1)
            $display("FAIL bus_reqcyc_hold: bus_reqcyc=%b before ack, expected 1", cif.bus_reqcyc);
        else
            n_pass++;
        cif.bus_reqack = 1'b1;
        tick();
        cif.bus_reqack = 1'b0;
        n_checks++;
        if (cif.bus_reqcyc !== 1'b0)
            $display("FAIL bus_reqcyc_drop: bus_reqcyc=%b after ack, expected 0", cif.bus_reqcyc);
        else
            n_pass++;
    endtask

    // Drives n good beats (data base+k) with 'gap' idle cycles between them;
    // a wrong-tag beat is inserted before good beat bad_idx (-1 for none).
    task automatic send_beats(input int g, input logic [T-1:0] tag, input logic [W-1:0] base,
                              input int n, input int gap, input int bad_idx);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            if (k == bad_idx) begin
                cif.bus_respcyc = 1'b1;
                cif.bus_resp    = W'(64'hDEAD);
                cif.bus_resptag = tag ^ T'(1);
                tick();
                cif.bus_respcyc = 1'b0;
            end
            cif.bus_respcyc = 1'b1;
            cif.bus_resp    = base + W'(k);
            cif.bus_resptag = tag;
            e.client = g;
            e.data   = base + W'(k);
            e.tag    = tag;
            exp_q.push_back(e);
            tick();
            cif.bus_respcyc = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic check_done(input string name, input int exp_acks, input int exp_grants);
        n_checks++;
        if (exp_q.size() != 0 || resp_acks != exp_acks || reqack_pulses != exp_grants)
            $display("FAIL %s: pending=%0d acks=%0d grants=%0d, expected pending=0 acks=%0d grants=%0d",
                     name, exp_q.size(), resp_acks, reqack_pulses, exp_acks, exp_grants);
        else
            n_pass++;
    endtask

    task automatic check_outputs_zero(input string name);
        n_checks++;
        if ({cif.cache_reqack, cif.cache_respcyc, cif.cache_resp, cif.cache_resptag,
             cif.bus_reqcyc, cif.bus_req, cif.bus_reqtag, cif.bus_respack} !== '0)
            $display("FAIL %s: reqack=%b respcyc=%b resp=%h resptag=%h bus_reqcyc=%b bus_req=%h bus_reqtag=%h bus_respack=%b, expected all 0",
                     name, cif.cache_reqack, cif.cache_respcyc, cif.cache_resp, cif.cache_resptag,
                     cif.bus_reqcyc, cif.bus_req, cif.bus_reqtag, cif.bus_respack);
        else
            n_pass++;
    endtask

    // Stray beat in IDLE must be neither acked nor forwarded.
    task automatic stray_beat(input string name);
        cif.bus_respcyc = 1'b1;
        cif.bus_resp    = W'(64'hBAD);
        cif.bus_resptag = T'(13'h1AB);
        tick();
        cif.bus_respcyc = 1'b0;
        n_checks++;
        if (cif.bus_respack !== 1'b0 || cif.cache_respcyc !== 2'b00)
            $display("FAIL %s: bus_respack=%b respcyc=%b, expected 0/00", name, cif.bus_respack, cif.cache_respcyc);
        else
            n_pass++;
    endtask

    task automatic test_reset();
        int t;
        clear_inputs();
        cif.cache_reqcyc = 2'b11;
        cif.bus_respcyc  = 1'b1;
        reset = 1'b0;
        repeat (2) tick();
        check_outputs_zero("reset_outputs");
        do_reset();
        tick();
        check_outputs_zero("idle_after_reset");
        t = 0;
    endtask

    task automatic test_single();
        int t;
        do_reset();
        set_client(0, 64'h1000, 13'h055);
        wait_grant(0, t);
        bus_accept(64'h1000, 13'h055, 2);
        send_beats(0, 13'h055, 64'h0, 8, 0, -1);
        stray_beat("single_idle_after_8");
        check_done("single_done", 8, 1);
    endtask

    task automatic test_both();
        int t;
        do_reset();
        set_client(0, 64'h2000, 13'h011);
        set_client(1, 64'h3000, 13'h122);
        wait_grant(0, t);
        bus_accept(64'h2000, 13'h011, 1);
        send_beats(0, 13'h011, 64'h100, 8, 0, -1);
        wait_grant(1, t);
        n_checks++;
        if (t !== 1)
            $display("FAIL no_idle_gap: client 1 granted after %0d cycles, expected 1", t);
        else
            n_pass++;
        bus_accept(64'h3000, 13'h122, 0);
        send_beats(1, 13'h122, 64'h200, 8, 1, -1);
        check_done("both_done", 16, 2);
    endtask

    task automatic test_round_robin();
        int t;
        resp_acks = 0;
        reqack_pulses = 0;
        // Client 1 was served last.
        set_client(0, 64'h4000, 13'h003);
        set_client(1, 64'h5000, 13'h004);
        wait_grant(0, t);
        bus_accept(64'h4000, 13'h003, 0);
        send_beats(0, 13'h003, 64'h300, 8, 0, -1);
        wait_grant(1, t);
        bus_accept(64'h5000, 13'h004, 0);
        send_beats(1, 13'h004, 64'h400, 8, 0, -1);
        set_client(0, 64'h6000, 13'h005);
        wait_grant(0, t);
        bus_accept(64'h6000, 13'h005, 1);
        send_beats(0, 13'h005, 64'h500, 8, 0, -1);
        // Client 0 was served last.
        set_client(0, 64'h7000, 13'h006);
        set_client(1, 64'h8000, 13'h007);
        wait_grant(1, t);
        bus_accept(64'h8000, 13'h007, 0);
        send_beats(1, 13'h007, 64'h600, 8, 0, -1);
        wait_grant(0, t);
        bus_accept(64'h7000, 13'h006, 0);
        send_beats(0, 13'h006, 64'h700, 8, 0, -1);
        check_done("rr_done", 40, 5);
    endtask

    task automatic test_gaps();
        int t;
        do_reset();
        stray_beat("stray_in_idle");
        set_client(0, 64'h9000, 13'h0F0);
        wait_grant(0, t);
        bus_accept(64'h9000, 13'h0F0, 3);
        send_beats(0, 13'h0F0, 64'h800, 8, 2, -1);
        stray_beat("gaps_idle_after_8");
        check_done("gaps_done", 8, 1);
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        set_client(1, 64'hA000, 13'h0AA);
        wait_grant(1, t);
        bus_accept(64'hA000, 13'h0AA, 0);
        send_beats(1, 13'h0AA, 64'h900, 4, 0, -1);
        cif.bus_respcyc = 1'b1;
        cif.bus_resp    = 64'h904;
        cif.bus_resptag = 13'h0AA;
        reset = 1'b0;
        #1;
        check_outputs_zero("reset_mid_burst");
        tick();
        check_outputs_zero("reset_held");
        clear_inputs();
        reset = 1'b1;
        exp_q.delete();
        resp_acks = 0;
        reqack_pulses = 0;
        set_client(0, 64'hB000, 13'h0BB);
        wait_grant(0, t);
        bus_accept(64'hB000, 13'h0BB, 1);
        send_beats(0, 13'h0BB, 64'hA00, 8, 0, -1);
        stray_beat("reset_mid_idle_after_8");
        check_done("reset_mid_done", 8, 1);
    endtask

`ifdef ARB_TAGCHECK_EN
    task automatic test_tagcheck();
        int t;
        do_reset();
        n_checks++;
        if (err_tag !== 1'b0)
            $display("FAIL err_tag_reset: err_tag=%b, expected 0", err_tag);
        else
            n_pass++;
        set_client(0, 64'hC000, 13'h0CC);
        wait_grant(0, t);
        bus_accept(64'hC000, 13'h0CC, 0);
        send_beats(0, 13'h0CC, 64'hB00, 8, 0, 3);
        n_checks++;
        if (err_tag !== 1'b1)
            $display("FAIL err_tag_set: err_tag=%b, expected 1", err_tag);
        else
            n_pass++;
        stray_beat("tag_idle_after_8");
        check_done("tag_done", 9, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_both();
        test_round_robin();
        test_gaps();
        test_reset_mid();
`ifdef ARB_TAGCHECK_EN
        test_tagcheck();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter WORDSIZE, default 64, address/data word width in bits.
REQ-002 Parameter TAGWIDTH, default 13, request/response tag width in bits.
REQ-003 Parameter BEATS, default 8, response beats per line fill.
REQ-004 clk  in  1  sole clock; all state changes on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 cache_reqcyc  in  2  per-client request valid; client 0 = I-cache, client 1 = D-cache.
REQ-007 cache_req  in  2*WORDSIZE  per-client line address; client i occupies bits [i*WORDSIZE +: WORDSIZE].
REQ-008 cache_reqtag  in  2*TAGWIDTH  per-client request tag, packed as cache_req.
REQ-009 cache_reqack  out  2  per-client one-cycle request accept.
REQ-010 cache_respcyc  out  2  per-client response beat valid.
REQ-011 cache_resp  out  WORDSIZE  response data, shared by both clients.
REQ-012 cache_resptag  out  TAGWIDTH  response tag, shared by both clients.
REQ-013 cache_respack  in  2  per-client response ack; sampled, no effect on FSM.
REQ-014 bus_reqcyc / bus_req / bus_reqtag  out  1 / WORDSIZE / TAGWIDTH  memory-side request.
REQ-015 bus_reqack  in  1  memory accepts the request.
REQ-016 bus_respcyc / bus_resp / bus_resptag  in  1 / WORDSIZE / TAGWIDTH  memory response beat.
REQ-017 bus_respack  out  1  per-beat ack to memory.

Function
REQ-018 The FSM SHALL have states IDLE, REQ and XFER.
REQ-019 In IDLE, with any cache_reqcyc high in cycle N, the arbiter SHALL grant one client, latch its req/reqtag, and in N+1 pulse cache_reqack[g] for one cycle, assert bus_reqcyc with the latched values, and enter REQ.
REQ-020 Arbitration SHALL be round-robin: with both requesting, the client not granted last wins; after reset, client 0 wins.
REQ-021 In REQ, bus_reqcyc SHALL stay high until bus_reqack is sampled high; it SHALL deassert in the following cycle, and the FSM SHALL enter XFER.
REQ-022 Each bus_respcyc sampled high in REQ or XFER at cycle M is one beat. In M+1 the arbiter SHALL drive cache_respcyc[g]=1, cache_resp=bus_resp, cache_resptag=bus_resptag and bus_respack=1; otherwise those valid/ack outputs are 0.
REQ-023 bus_respcyc outside REQ/XFER SHALL be ignored and SHALL not be acked.
REQ-024 A 3-bit beat counter SHALL count accepted beats; on the BEATS-th beat it SHALL reset to 0 and the FSM SHALL return to IDLE in M+1.
REQ-025 A new grant MAY be sampled in the same cycle the FSM returns to IDLE.
REQ-026 Requests arriving while busy SHALL be held pending; cache_reqcyc is evaluated only in IDLE.
REQ-027 The ungranted client SHALL never see cache_reqack or cache_respcyc.

Reset
REQ-028 On reset low, the FSM SHALL go to IDLE, the beat counter to 0 and last-grant to 1, immediately and regardless of any transfer in progress.
REQ-029 During reset, all outputs SHALL be 0, including any partially forwarded burst.

Configuration
REQ-030 With ARB_TAGCHECK_EN defined, a beat whose bus_resptag differs from the latched reqtag SHALL be acked on bus_respack but not forwarded or counted, and sticky output err_tag (1 bit, cleared only by reset) SHALL set.
REQ-031 Without ARB_TAGCHECK_EN, tags SHALL not be compared, every beat SHALL be forwarded and counted, and the err_tag port SHALL not exist.

Verification
REQ-032 Client 0 only, req=0x1000, bus_reqack 2 cycles later, 8 back-to-back beats 0..7 -> one reqack[0]; bus_req=0x1000; cache_respcyc[0] with data 0..7 each one cycle after its beat; IDLE after beat 8.
REQ-033 Both clients request in the same cycle after reset -> client 0 served first, then client 1 with no intervening idle grant.
REQ-034 Client 1 served, then both request -> client 0 wins.
REQ-035 Beats with 2-cycle gaps, plus a stray bus_respcyc in IDLE -> exactly 8 forwarded beats; the stray beat is not acked.
REQ-036 Reset asserted after beat 4 -> all outputs 0 at once; after release, a fresh request completes a full 8-beat burst.
REQ-037 ARB_TAGCHECK_EN defined, beat 3 carries the wrong tag -> not forwarded, err_tag=1, burst completes after 8 matching beats.
